antilog_conv: RTL and testbench

ANTILOG_CONV -- requirements
Module: antilog_conv

---
 rtl/antilog_conv.sv | 144 ++++++++++++++
 tb/tb_antilog_conv.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/antilog_conv.sv
// antilog_conv: converts an unsigned log2 value {int[7:4], frac[3:0]} into a
// 16-bit linear magnitude through a 3-stage valid/ready pipeline.
//   S1: int, frac, zero flag and the correction term corr[frac]
//   S2: mantissa m = 64 + 4*frac - corr (7 bits, 64..127)
//   S3: lin_out = (m << int) >> 6, forced to 0 for zero-flagged operands
// Each stage advances when it is empty or when its successor advances, so a
// full pipeline shifts in lockstep and a stalled output backs up to in_ready.
module antilog_conv (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_zero,
  input  logic [7:0]  log_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] lin_out
);

  // Piecewise correction that bends the linear 64 + 4*frac ramp onto 2^(frac/16).
  function automatic logic [2:0] corr_lut(input logic [3:0] frac);
    logic [2:0] corr;
    case (frac)
      4'd0:    corr = 3'd0;
      4'd1:    corr = 3'd1;
      4'd2:    corr = 3'd2;
      4'd3:    corr = 3'd3;
      4'd4:    corr = 3'd4;
      4'd5:    corr = 3'd5;
      4'd6:    corr = 3'd5;
      4'd7:    corr = 3'd5;
      4'd8:    corr = 3'd5;
      4'd9:    corr = 3'd5;
      4'd10:   corr = 3'd5;
      4'd11:   corr = 3'd5;
      4'd12:   corr = 3'd4;
      4'd13:   corr = 3'd4;
      4'd14:   corr = 3'd3;
      4'd15:   corr = 3'd1;
      default: corr = 3'd0;
    endcase
    return corr;
  endfunction

  // Stage valids (reset) and datapath registers (only lin_q is reset).
  logic        s1_v_q, s1_v_d;
  logic [3:0]  s1_int_q, s1_int_d;
  logic [3:0]  s1_frac_q, s1_frac_d;
  logic        s1_zero_q, s1_zero_d;
  logic [2:0]  s1_corr_q, s1_corr_d;
  logic        s2_v_q, s2_v_d;
  logic [3:0]  s2_int_q, s2_int_d;
  logic        s2_zero_q, s2_zero_d;
  logic [6:0]  s2_m_q, s2_m_d;
  logic        s3_v_q, s3_v_d;
  logic [15:0] lin_q, lin_d;

  logic        adv1_s, adv2_s, adv3_s;

  // Advance chain: a stage moves when empty or when the stage behind it drains.
  always_comb begin
    adv3_s   = ~s3_v_q | out_ready;
    adv2_s   = ~s2_v_q | adv3_s;
    adv1_s   = ~s1_v_q | adv2_s;
    in_ready = adv1_s & ~rst;
  end

  // Next-state for all stages; a stage holds its contents when it cannot advance.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_int_d  = s1_int_q;
    s1_frac_d = s1_frac_q;
    s1_zero_d = s1_zero_q;
    s1_corr_d = s1_corr_q;
    s2_v_d    = s2_v_q;
    s2_int_d  = s2_int_q;
    s2_zero_d = s2_zero_q;
    s2_m_d    = s2_m_q;
    s3_v_d    = s3_v_q;
    lin_d     = lin_q;

    if (adv1_s) begin
      s1_v_d    = in_valid;
      s1_int_d  = log_in[7:4];
      s1_frac_d = log_in[3:0];
      s1_zero_d = in_zero;
      s1_corr_d = corr_lut(log_in[3:0]);
    end else begin
      s1_v_d = s1_v_q;
    end

    if (adv2_s) begin
      s2_v_d    = s1_v_q;
      s2_int_d  = s1_int_q;
      s2_zero_d = s1_zero_q;
      // 64 + 60 tops out at 124 and corr <= 5, so 7 bits never wrap.
      s2_m_d    = 7'd64 + {1'b0, s1_frac_q, 2'b00} - {4'b0000, s1_corr_q};
    end else begin
      s2_v_d = s2_v_q;
    end

    if (adv3_s) begin
      s3_v_d = s2_v_q;
      if (s2_zero_q) begin
        lin_d = 16'd0;
      end else begin
        // 22-bit intermediate holds 127 << 15; after >> 6 the result fits 16 bits.
        lin_d = 16'((({15'd0, s2_m_q}) << s2_int_q) >> 5'd6);
      end
    end else begin
      s3_v_d = s3_v_q;
    end
  end

  // Stage valids and the output value clear asynchronously on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s3_v_q <= 1'b0;
      lin_q  <= 16'd0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s3_v_q <= s3_v_d;
      lin_q  <= lin_d;
    end
  end

  // Datapath registers are only observed behind a set valid, so no reset needed.
  always_ff @(posedge clk) begin
    s1_int_q  <= s1_int_d;
    s1_frac_q <= s1_frac_d;
    s1_zero_q <= s1_zero_d;
    s1_corr_q <= s1_corr_d;
    s2_int_q  <= s2_int_d;
    s2_zero_q <= s2_zero_d;
    s2_m_q    <= s2_m_d;
  end

  assign out_valid = s3_v_q;
  assign lin_out   = lin_q;

endmodule

// File: tb/tb_antilog_conv.sv
// Self-checking bench for antilog_conv: scoreboard queue filled on input
// transfers and drained on output transfers, plus directed latency,
// backpressure and reset scenarios and a randomized full-range sweep.
module tb_antilog_conv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_zero = 1'b0;
  logic [7:0]  log_in = 8'd0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] lin_out;

  antilog_conv dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_zero   (in_zero),
    .log_in    (log_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lin_out   (lin_out)
  );

  always #5 clk = ~clk;

  localparam int CORR_TAB [16] = '{0, 1, 2, 3, 4, 5, 5, 5, 5, 5, 5, 5, 4, 4, 3, 1};

  int n_chk = 0;
  int n_pass = 0;
  int sb[$];
  int obs_acc, obs_fire, obs_ov, obs_ir, obs_lin;
  int n_in = 0;
  int n_out = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: 2^(int + frac/16) approximated as m * 2^int / 64.
  function automatic int model(input logic z, input logic [7:0] li);
    int e, f, m;
    if (z) return 0;
    e = int'(li[7:4]);
    f = int'(li[3:0]);
    m = 64 + 4 * f - CORR_TAB[f];
    return (m * (1 << e)) / 64;
  endfunction

  // One clock cycle: drive at negedge, sample 1ns later, score handshakes.
  task automatic step(input logic iv, input logic iz, input logic [7:0] li,
                      input logic ordy, input int ex);
    int e;
    @(negedge clk);
    in_valid  = iv;
    in_zero   = iz;
    log_in    = li;
    out_ready = ordy;
    #1;
    obs_ov   = int'(out_valid);
    obs_ir   = int'(in_ready);
    obs_lin  = int'(lin_out);
    obs_fire = 0;
    obs_acc  = 0;
    if (out_valid && out_ready) begin
      obs_fire = 1;
      n_out++;
      if (sb.size() == 0) begin
        check_val("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("lin_out", int'(lin_out), e);
      end
    end
    if (in_valid && in_ready) begin
      obs_acc = 1;
      n_in++;
      sb.push_back(ex < 0 ? model(iz, li) : ex);
    end
  endtask

  initial begin
    logic [7:0] vals [5];
    int idx;
    int hold;
    int cyc;
    logic [7:0] li;
    vals = '{8'h10, 8'h21, 8'h52, 8'h93, 8'hC7};

    // Reset state, with the downstream ready so in_ready would otherwise be 1.
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1;
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_lin_out", int'(lin_out), 0);
    check_val("rst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b1, -1);
    check_val("post_rst_in_ready", obs_ir, 1);

    // Single sample 0x38 -> 11, out_valid appears exactly 3 cycles later.
    step(1'b1, 1'b0, 8'h38, 1'b1, 11);
    check_val("lat_accept", obs_acc, 1);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, -1);
      check_val("lat_out_valid", obs_ov, (k == 3) ? 1 : 0);
    end

    // Back-to-back 0x00, 0x40, 0xFF -> 1, 16, 62976 on consecutive cycles.
    step(1'b1, 1'b0, 8'h00, 1'b1, 1);
    step(1'b1, 1'b0, 8'h40, 1'b1, 16);
    step(1'b1, 1'b0, 8'hFF, 1'b1, 62976);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, -1);
      check_val("b2b_fire", obs_fire, (k <= 3) ? 1 : 0);
    end

    // Zero flag overrides log_in.
    step(1'b1, 1'b1, 8'hFF, 1'b1, 0);
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1, -1);
    check_val("zero_drained", sb.size(), 0);

    // Backpressure: 5 offered with out_ready=0, only 3 fit; output holds.
    idx = 0;
    hold = 0;
    for (int k = 0; k < 6; k++) begin
      step(idx < 5, 1'b0, vals[idx < 5 ? idx : 4], 1'b0, -1);
      idx += obs_acc;
      if (k == 3) hold = obs_lin;
      if (k > 3) begin
        check_val("bp_hold_valid", obs_ov, 1);
        check_val("bp_hold_lin", obs_lin, hold);
      end
    end
    check_val("bp_accepted", idx, 3);
    check_val("bp_in_ready", obs_ir, 0);
    check_val("bp_head_value", hold, model(1'b0, vals[0]));
    for (int k = 0; k < 30 && (idx < 5 || sb.size() != 0); k++) begin
      step(idx < 5, 1'b0, vals[idx < 5 ? idx : 4], 1'b1, -1);
      idx += obs_acc;
    end
    check_val("bp_all_in", idx, 5);
    check_val("bp_drained", sb.size(), 0);

    // Asynchronous reset with samples in flight, asserted mid-cycle.
    step(1'b1, 1'b0, 8'h38, 1'b0, -1);
    step(1'b1, 1'b0, 8'h40, 1'b0, -1);
    step(1'b1, 1'b0, 8'h55, 1'b0, -1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_out_valid", int'(out_valid), 0);
    check_val("arst_lin_out", int'(lin_out), 0);
    check_val("arst_in_ready", int'(in_ready), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, -1);
      check_val("no_stale", obs_ov, 0);
    end
    step(1'b1, 1'b0, 8'h38, 1'b1, 11);
    check_val("post_arst_accept", obs_acc, 1);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, -1);
      check_val("post_arst_valid", obs_ov, (k == 3) ? 1 : 0);
    end

    // Full sweep of log_in with random zero flags, in_valid and out_ready.
    idx = 0;
    n_in = 0;
    n_out = 0;
    cyc = 0;
    while ((idx < 256 || sb.size() != 0) && cyc < 20000) begin
      li = idx[7:0];
      step((idx < 256) && ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           li, ($urandom_range(0, 3) != 0), -1);
      idx += obs_acc;
      cyc++;
    end
    check_val("sweep_all_in", idx, 256);
    check_val("sweep_drained", sb.size(), 0);
    check_val("sweep_in_eq_out", n_out, n_in);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
